// File: rtl/store_align_unit.sv
// -----------------------------------------------------------------------------
// store_align_unit
//   Store-side lane formatter and write buffer for the MIPS32 MEM stage.
//   SB/SH/SW requests are turned into a word address, replicated write data
//   and byte enables. The result is buffered in a small FIFO that drains to
//   data memory over a valid/ready handshake. A misaligned address raises
//   AdES (code 5) and a reserved size raises RI (code 10). A faulting request
//   completes its handshake, is never buffered, and produces a one-cycle
//   exception pulse on the following cycle.
//
// Parameters
//   DEPTH       write-buffer entries (power of two, >= 2)
//   BIG_ENDIAN  0: byte offset k drives lane k, 1: byte offset k drives lane 3-k
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               synchronous squash of buffer and pending exception
//   req_valid/ready     request handshake (ready = not full and no flush)
//   req_addr/data/size  byte address, rt value, 00 byte / 01 half / 10 word
//   mem_valid/ready     head entry handshake toward data memory
//   mem_addr/wdata/be   head entry: word address, lane data, byte enables
//   exc_valid           one-cycle exception pulse
//   exc_code            5 = AdES, 10 = RI (held until the next exception)
//   exc_badvaddr        faulting byte address (held until the next exception)
//   count               buffer occupancy
// -----------------------------------------------------------------------------
module store_align_unit #(
    parameter int DEPTH      = 2,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_data,
    input  logic [1:0]               req_size,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     exc_valid,
    output logic [4:0]               exc_code,
    output logic [31:0]              exc_badvaddr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [4:0]    EXC_ADES = 5'd5;
    localparam logic [4:0]    EXC_RI   = 5'd10;

    // Replicate the low byte/half of rt across the word so any lane can be picked by be.
    function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{data[7:0]}};
            2'b01:   w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    // Little-endian byte enables, mirrored when the lane mapping is big-endian.
    function automatic logic [3:0] fmt_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return BIG_ENDIAN ? {be[0], be[1], be[2], be[3]} : be;
    endfunction

    logic [31:0]   ent_addr_r  [DEPTH];
    logic [31:0]   ent_wdata_r [DEPTH];
    logic [3:0]    ent_be_r    [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          valid_r;
    logic          exc_valid_r;
    logic [4:0]    exc_code_r;
    logic [31:0]   exc_badvaddr_r;

    logic          fault_s;
    logic [4:0]    code_s;
    logic          ready_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_nxt_s;

    // Classify the request: RI on reserved size wins over any alignment check.
    always_comb begin
        fault_s = 1'b0;
        code_s  = EXC_ADES;
        case (req_size)
            2'b00: begin
                fault_s = 1'b0;
                code_s  = EXC_ADES;
            end
            2'b01: begin
                fault_s = req_addr[0];
                code_s  = EXC_ADES;
            end
            2'b10: begin
                fault_s = (req_addr[1:0] != 2'b00);
                code_s  = EXC_ADES;
            end
            2'b11: begin
                fault_s = 1'b1;
                code_s  = EXC_RI;
            end
            default: begin
                fault_s = 1'b1;
                code_s  = EXC_RI;
            end
        endcase
    end

    // Ready ignores mem_ready on purpose: a full buffer never passes a store through.
    assign ready_s  = (count_r < DEPTH_C) && !flush;
    assign accept_s = req_valid && ready_s;
    assign push_s   = accept_s && !fault_s;
    assign pop_s    = valid_r && mem_ready;

    // Next occupancy; flush discards everything including a same-cycle pop.
    always_comb begin
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO pointers, occupancy and head-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != {CW{1'b0}});
        end
    end

    // Entry storage; cleared on reset so mem_* read back as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_r[i]  <= 32'h0000_0000;
                ent_wdata_r[i] <= 32'h0000_0000;
                ent_be_r[i]    <= 4'b0000;
            end
        end else if (push_s) begin
            ent_addr_r[wr_ptr_r]  <= {req_addr[31:2], 2'b00};
            ent_wdata_r[wr_ptr_r] <= fmt_wdata(req_size, req_data);
            ent_be_r[wr_ptr_r]    <= fmt_be(req_size, req_addr[1:0]);
        end
    end

    // Exception pulse; code and bad address stay until the next accepted fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_valid_r    <= 1'b0;
            exc_code_r     <= 5'd0;
            exc_badvaddr_r <= 32'h0000_0000;
        end else if (accept_s && fault_s && !flush) begin
            exc_valid_r    <= 1'b1;
            exc_code_r     <= code_s;
            exc_badvaddr_r <= req_addr;
        end else begin
            exc_valid_r    <= 1'b0;
        end
    end

    assign req_ready    = ready_s;
    assign mem_valid    = valid_r;
    assign mem_addr     = ent_addr_r[rd_ptr_r];
    assign mem_wdata    = ent_wdata_r[rd_ptr_r];
    assign mem_be       = ent_be_r[rd_ptr_r];
    assign exc_valid    = exc_valid_r;
    assign exc_code     = exc_code_r;
    assign exc_badvaddr = exc_badvaddr_r;
    assign count        = count_r;

    store_align_unit_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );

endmodule

// -----------------------------------------------------------------------------
// store_align_unit_chk
//   Occupancy invariants for the write buffer: bounded by DEPTH, no pop from
//   an empty buffer, and count equal to pushes minus pops since flush/reset.
// Ports
//   clk, rst_n, flush   as in the parent
//   push, pop           FIFO write / read strobes
//   count               parent occupancy register
// -----------------------------------------------------------------------------
module store_align_unit_chk #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [$clog2(DEPTH):0] count
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] model_r;

    // Independent push/pop tally used as the reference occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_r <= {CW{1'b0}};
        end else if (flush) begin
            model_r <= {CW{1'b0}};
        end else begin
            model_r <= model_r + CW'(push) - CW'(pop);
        end
    end

    a_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop |-> (count != {CW{1'b0}}));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> (count < DEPTH_C) || pop);
    a_track: assert property (@(posedge clk) disable iff (!rst_n) count == model_r);

endmodule
